control_seq: RTL and testbench

CONTROL_SEQ -- requirements
Module: control_seq

---
 rtl/microc_pkg.sv | 48 ++++
 rtl/control_decode.sv | 57 +++++
 rtl/control_seq.sv | 106 ++++++++++
 tb/tb_control_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/microc_pkg.sv
// Shared types and constants for the microcontroller sequencer.
// Holds state encoding, opcode map and the safe control set.
package microc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_HALT,
        S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        K_SEQ,
        K_HALT,
        K_WAIT,
        K_TRAP
    } kind_e;

    typedef struct packed {
        logic       pc_en;
        logic       we3;
        logic       wez;
        logic       s_inc;
        logic       s_abs;
        logic       s_inm;
        logic [2:0] op;
    } ctl_t;

    localparam ctl_t CTL_SAFE = '{
        pc_en: 1'b0,
        we3:   1'b0,
        wez:   1'b0,
        s_inc: 1'b1,
        s_abs: 1'b0,
        s_inm: 1'b0,
        op:    3'b000
    };

    localparam logic [5:0] OP_LI   = 6'b100000;
    localparam logic [5:0] OP_J    = 6'b100001;
    localparam logic [5:0] OP_JZ   = 6'b100010;
    localparam logic [5:0] OP_JNZ  = 6'b100011;
    localparam logic [5:0] OP_JR   = 6'b100100;
    localparam logic [5:0] OP_HALT = 6'b100101;
    localparam logic [5:0] OP_NOP  = 6'b100110;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: RUN-state controls and the
// instruction class that steers the sequencer.
module control_decode
    import microc_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic       z_i,
    output ctl_t       ctl_o,
    output kind_e      kind_o
);

    always_comb begin
        ctl_o  = CTL_SAFE;
        kind_o = K_SEQ;
        unique case (1'b1)
            !opcode_i[5]: begin
                ctl_o.pc_en = 1'b1;
                ctl_o.we3   = 1'b1;
                ctl_o.wez   = 1'b1;
                ctl_o.op    = opcode_i[4:2];
            end
            (opcode_i[5:4] == 2'b11): begin
                // WAIT 0 degenerates to a plain NOP
                if (opcode_i[3:0] == 4'd0) ctl_o.pc_en = 1'b1;
                else kind_o = K_WAIT;
            end
            (opcode_i == OP_LI): begin
                ctl_o.pc_en = 1'b1;
                ctl_o.we3   = 1'b1;
                ctl_o.s_inm = 1'b1;
            end
            (opcode_i == OP_J): begin
                ctl_o.pc_en = 1'b1;
                ctl_o.s_inc = 1'b0;
                ctl_o.s_abs = 1'b1;
            end
            (opcode_i == OP_JZ): begin
                ctl_o.pc_en = 1'b1;
                ctl_o.s_inc = !z_i;
                ctl_o.s_abs = z_i;
            end
            (opcode_i == OP_JNZ): begin
                ctl_o.pc_en = 1'b1;
                ctl_o.s_inc = z_i;
                ctl_o.s_abs = !z_i;
            end
            (opcode_i == OP_JR): begin
                ctl_o.pc_en = 1'b1;
                ctl_o.s_inc = 1'b0;
            end
            (opcode_i == OP_NOP): ctl_o.pc_en = 1'b1;
            (opcode_i == OP_HALT): kind_o = K_HALT;
            default: kind_o = K_TRAP;
        endcase
    end

endmodule

// File: rtl/control_seq.sv
// Control sequencer: IDLE/RUN/WAIT/HALT/TRAP FSM, wait counter
// and saturating retired-instruction counter.
module control_seq
    import microc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_abs,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op,
    output logic             pc_en,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    ctl_t             dec_ctl, ctl;
    kind_e            dec_kind;

    control_decode u_dec (
        .opcode_i (opcode),
        .z_i      (z),
        .ctl_o    (dec_ctl),
        .kind_o   (dec_kind)
    );

    always_comb begin
        ctl     = CTL_SAFE;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                ctl = dec_ctl;
                case (dec_kind)
                    K_HALT: state_d = S_HALT;
                    K_TRAP: state_d = S_TRAP;
                    K_WAIT: begin
                        state_d = S_WAIT;
                        cnt_d   = opcode[3:0];
                    end
                    default: ;
                endcase
            end
            S_WAIT: begin
                // last wait cycle retires the instruction
                if (cnt_q == 4'd1) begin
                    ctl.pc_en = 1'b1;
                    state_d   = S_RUN;
                    cnt_d     = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HALT: begin
                if (start) begin
                    ctl.pc_en = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_TRAP: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (ctl.pc_en && retired_q != '1)
            retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
        end
    end

    assign pc_en   = ctl.pc_en;
    assign we3     = ctl.we3;
    assign wez     = ctl.wez;
    assign s_inc   = ctl.s_inc;
    assign s_abs   = ctl.s_abs;
    assign s_inm   = ctl.s_inm;
    assign op      = ctl.op;
    assign halted  = (state_q == S_HALT);
    assign error   = (state_q == S_TRAP);
    assign retired = retired_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq with a narrow retired counter
// so saturation is reached within the sequence.
module tb_control_seq;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   opcode = 6'b000000;
    logic         z = 1'b0;
    logic         s_inc, s_abs, s_inm, we3, wez, pc_en;
    logic         halted, error;
    logic [2:0]   op;
    logic [W-1:0] retired;
    logic [8:0]   ctl;

    int vectors = 0;
    int miscompares = 0;

    // pc_en,we3,wez,s_inc,s_abs,s_inm,op
    localparam logic [8:0] SAFE = 9'b000100000;
    localparam logic [8:0] SEQ  = 9'b100100000;
    localparam logic [8:0] JMP  = 9'b100010000;

    control_seq #(.CNT_W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .opcode  (opcode),
        .z       (z),
        .s_inc   (s_inc),
        .s_abs   (s_abs),
        .s_inm   (s_inm),
        .we3     (we3),
        .wez     (wez),
        .op      (op),
        .pc_en   (pc_en),
        .halted  (halted),
        .error   (error),
        .retired (retired)
    );

    assign ctl = {pc_en, we3, wez, s_inc, s_abs, s_inm, op};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) cyc();
        #1;
        chk("rst_ctl", 16'(ctl), 16'(SAFE));
        chk("rst_ret", 16'(retired), 16'd0);
        chk("rst_flags", 16'({halted, error}), 16'd0);

        reset = 1'b1;
        opcode = 6'b100000;
        start = 1'b1;
        #1;
        chk("idle_ctl", 16'(ctl), 16'(SAFE));
        cyc();
        start = 1'b0;
        #1;
        chk("li_ctl", 16'(ctl), 16'(9'b110101000));
        cyc();
        chk("li_ret", 16'(retired), 16'd1);

        opcode = 6'b001000;
        #1;
        chk("add_ctl", 16'(ctl), 16'(9'b111100010));
        cyc();

        opcode = 6'b100011;
        z = 1'b0;
        #1;
        chk("jnz_z0", 16'(ctl), 16'(JMP));
        cyc();
        z = 1'b1;
        #1;
        chk("jnz_z1", 16'(ctl), 16'(SEQ));
        cyc();
        opcode = 6'b100010;
        #1;
        chk("jz_z1", 16'(ctl), 16'(JMP));
        cyc();
        chk("ret5", 16'(retired), 16'd5);

        opcode = 6'b110011;
        #1;
        chk("wait_c1", 16'(ctl), 16'(SAFE));
        cyc();
        opcode = 6'b100101;
        #1;
        chk("wait_c2", 16'(ctl), 16'(SAFE));
        cyc();
        #1;
        chk("wait_c3", 16'(ctl), 16'(SAFE));
        chk("wait_ret", 16'(retired), 16'd5);
        cyc();
        #1;
        chk("wait_c4", 16'(ctl), 16'(SEQ));
        cyc();
        chk("wait_ret1", 16'(retired), 16'd6);

        #1;
        chk("halt_ctl", 16'(ctl), 16'(SAFE));
        chk("halt_pre", 16'(halted), 16'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            opcode = 6'(i);
            #1;
            chk("halted", 16'({halted, ctl}), 16'({1'b1, SAFE}));
            cyc();
        end
        start = 1'b1;
        opcode = 6'b100110;
        #1;
        chk("step_ctl", 16'(ctl), 16'(SEQ));
        cyc();
        start = 1'b0;
        chk("step_hlt", 16'(halted), 16'd0);
        chk("step_ret", 16'(retired), 16'd7);

        #1;
        chk("nop_ctl", 16'(ctl), 16'(SEQ));
        cyc();
        chk("sat_ret", 16'(retired), 16'd7);

        opcode = 6'b101010;
        #1;
        chk("ill_ctl", 16'(ctl), 16'(SAFE));
        cyc();
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("trap", 16'({error, halted, ctl}),
                16'({2'b10, SAFE}));
            cyc();
        end
        start = 1'b0;

        reset = 1'b0;
        #1;
        chk("trap_rst", 16'({error, retired}), 16'd0);
        chk("trap_rst_ctl", 16'(ctl), 16'(SAFE));
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("idle_hold", 16'({retired, ctl}), 16'(SAFE));
            cyc();
        end

        start = 1'b1;
        opcode = 6'b100110;
        cyc();
        start = 1'b0;
        cyc();
        chk("nop_ret", 16'(retired), 16'd1);
        opcode = 6'b111111;
        cyc();
        cyc();
        #1;
        chk("w15_c3", 16'(ctl), 16'(SAFE));
        reset = 1'b0;
        #1;
        chk("w15_rst", 16'({retired, ctl}), 16'(SAFE));
        cyc();
        #1;
        chk("w15_hold", 16'({halted, error, ctl}), 16'(SAFE));
        reset = 1'b1;
        cyc();
        chk("w15_idle", 16'({retired, ctl}), 16'(SAFE));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
